// File: rtl/nibble_stream_arbiter.sv
// rtl/nibble_stream_arbiter.sv - round-robin byte arbiter serializing granted bytes into a tagged nibble stream
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   req_val   in   [p_nreqs]    per-requester byte valid
//   req_msg   in   [8*p_nreqs]  requester i byte at [8i+7:8i]
//   req_rdy   out  [p_nreqs]    one-hot grant, zero outside the accept window
//   out_val   out  nibble valid
//   out_msg   out  [4]  nibble data
//   out_src   out  [2]  index of the requester owning the current byte
//   out_last  out  1 on the second nibble of a byte
//   out_rdy   in   downstream ready
//
// Build option: NIBBLE_STREAM_ARBITER_HI_FIRST_EN emits the high nibble first.

module nibble_stream_arbiter #(
    parameter int p_nreqs = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [p_nreqs-1:0]     req_val,
    input  logic [8*p_nreqs-1:0]   req_msg,
    output logic [p_nreqs-1:0]     req_rdy,
    output logic                   out_val,
    output logic [3:0]             out_msg,
    output logic [1:0]             out_src,
    output logic                   out_last,
    input  logic                   out_rdy
);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        SECOND
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] byte_q;
    logic [1:0] src_q;
    logic [1:0] ptr;

    logic       window;
    logic       found;
    logic [1:0] gnt_idx;
    logic       hs;
    logic [7:0] gnt_byte;
    logic [1:0] ptr_nxt;
    logic [3:0] first_nib;
    logic [3:0] second_nib;

`ifdef NIBBLE_STREAM_ARBITER_HI_FIRST_EN
    assign first_nib  = byte_q[7:4];
    assign second_nib = byte_q[3:0];
`else
    assign first_nib  = byte_q[3:0];
    assign second_nib = byte_q[7:4];
`endif

    // A new byte may be taken while idle, or in the same cycle the high
    // nibble leaves, which gives back-to-back bytes every two cycles.
    assign window = (state == IDLE) || ((state == SECOND) && out_rdy);

    // Round-robin search: first pass covers ptr..p_nreqs-1, second pass
    // wraps around to 0..ptr-1.
    always_comb begin
        found   = 1'b0;
        gnt_idx = 2'd0;
        for (int i = 0; i < p_nreqs; i++) begin
            if (!found && req_val[i] && (i >= int'(ptr))) begin
                found   = 1'b1;
                gnt_idx = 2'(i);
            end
        end
        for (int i = 0; i < p_nreqs; i++) begin
            if (!found && req_val[i] && (i < int'(ptr))) begin
                found   = 1'b1;
                gnt_idx = 2'(i);
            end
        end
    end

    assign hs = window && found;

    always_comb begin
        req_rdy  = '0;
        gnt_byte = 8'h00;
        for (int i = 0; i < p_nreqs; i++) begin
            if (hs && (gnt_idx == 2'(i))) begin
                req_rdy[i] = 1'b1;
                gnt_byte   = req_msg[8*i +: 8];
            end
        end
    end

    assign ptr_nxt = (gnt_idx == 2'(p_nreqs - 1)) ? 2'd0 : gnt_idx + 2'd1;

    always_comb begin
        state_nxt = state;
        out_val   = 1'b0;
        out_msg   = 4'h0;
        out_src   = 2'd0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                if (hs) state_nxt = FIRST;
            end
            FIRST: begin
                out_val = 1'b1;
                out_msg = first_nib;
                out_src = src_q;
                if (out_rdy) state_nxt = SECOND;
            end
            SECOND: begin
                out_val  = 1'b1;
                out_msg  = second_nib;
                out_src  = src_q;
                out_last = 1'b1;
                if (out_rdy) state_nxt = hs ? FIRST : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            byte_q <= 8'h00;
            src_q  <= 2'd0;
            ptr    <= 2'd0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                byte_q <= gnt_byte;
                src_q  <= gnt_idx;
                ptr    <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_nibble_stream_arbiter.sv
// tb/tb_nibble_stream_arbiter.sv - scoreboard bench for nibble_stream_arbiter

module tb_nibble_stream_arbiter;

    localparam int NREQ = 3;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_val;
    logic [8*NREQ-1:0] req_msg;
    logic [NREQ-1:0]   req_rdy;
    logic              out_val;
    logic [3:0]        out_msg;
    logic [1:0]        out_src;
    logic              out_last;
    logic              out_rdy;

    int vectors    = 0;
    int miscompares = 0;

    logic [6:0] exp_q[$];

    nibble_stream_arbiter #(.p_nreqs(NREQ)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_msg  (req_msg),
        .req_rdy  (req_rdy),
        .out_val  (out_val),
        .out_msg  (out_msg),
        .out_src  (out_src),
        .out_last (out_last),
        .out_rdy  (out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input logic [1:0] s);
`ifdef NIBBLE_STREAM_ARBITER_HI_FIRST_EN
        exp_q.push_back({b[7:4], s, 1'b0});
        exp_q.push_back({b[3:0], s, 1'b1});
`else
        exp_q.push_back({b[3:0], s, 1'b0});
        exp_q.push_back({b[7:4], s, 1'b1});
`endif
    endtask

    // One cycle: g is the expected grant index (-1 = no grant), ev the
    // expected out_val (-1 = don't care). A grant queues its two nibbles.
    task automatic cyc(input int g, input int ev);
        logic [NREQ-1:0] er;
        @(negedge clk);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("req_rdy", 32'(req_rdy), 32'(er));
        if (ev >= 0) check("out_val", 32'(out_val), 32'(ev));
        if (g >= 0) push_byte(req_msg[8*g +: 8], 2'(g));
        @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every valid nibble must match the scoreboard head; while
    // stalled the head is only peeked, so frozen outputs are checked too.
    always @(negedge clk) begin
        if (!reset && out_val) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected nibble: got %0h expected none at %0t",
                         {out_msg, out_src, out_last}, $time);
            end else begin
                check(out_rdy ? "nibble" : "stall hold",
                      32'({out_msg, out_src, out_last}), 32'(exp_q[0]));
                if (out_rdy) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset   = 1'b1;
        req_val = '0;
        req_msg = '0;
        out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_rdy", 32'(req_rdy), 32'd0);
        check("reset out_val", 32'(out_val), 32'd0);
        check("reset out_msg", 32'(out_msg), 32'd0);
        check("reset out_src", 32'(out_src), 32'd0);
        check("reset out_last", 32'(out_last), 32'd0);
        reset = 1'b0;

        // Single byte 0xA5 from requester 0.
        out_rdy = 1'b1;
        req_val = 3'b001;
        req_msg[7:0] = 8'hA5;
        cyc(0, 0);
        req_val = 3'b000;
        cyc(-1, 1);
        cyc(-1, 1);
        cyc(-1, 0);
        check_drained("single byte drained");

        // Requesters 0,1 always valid; ptr=1 here, so the first grant is 1.
        req_msg[7:0]  = 8'h12;
        req_msg[15:8] = 8'h34;
        req_val = 3'b011;
        cyc(1, 0);
        cyc(-1, 1);
        cyc(0, 1);
        cyc(-1, 1);
        cyc(1, 1);
        cyc(-1, 1);
        cyc(0, 1);
        cyc(-1, 1);
        req_val = 3'b000;
        cyc(-1, 1);
        cyc(-1, 0);
        check_drained("alternating drained");

        // Backpressure: 3 stall cycles in FIRST, then 3 in SECOND, with a
        // competing request present that must not be granted.
        req_msg[7:0] = 8'h96;
        out_rdy = 1'b0;
        req_val = 3'b001;
        cyc(0, 0);
        req_val = 3'b010;
        repeat (3) cyc(-1, 1);
        out_rdy = 1'b1;
        req_val = 3'b000;
        cyc(-1, 1);
        out_rdy = 1'b0;
        req_val = 3'b010;
        repeat (3) cyc(-1, 1);
        out_rdy = 1'b1;
        req_val = 3'b000;
        cyc(-1, 1);
        cyc(-1, 0);
        check_drained("stall drained");

        // Three requesters, pattern 101 held, then requester 1 joins.
        req_msg = {8'h65, 8'h43, 8'h21};
        req_val = 3'b101;
        cyc(2, 0);
        cyc(-1, 1);
        cyc(0, 1);
        cyc(-1, 1);
        cyc(2, 1);
        cyc(-1, 1);
        cyc(0, 1);
        req_val = 3'b111;
        cyc(-1, 1);
        cyc(1, 1);
        cyc(-1, 1);
        cyc(2, 1);
        req_val = 3'b000;
        cyc(-1, 1);
        cyc(-1, 1);
        cyc(-1, 0);
        check_drained("round robin drained");

        // Reset while the high nibble of 0xC3 is pending.
        req_msg[7:0] = 8'hC3;
        req_val = 3'b001;
        cyc(0, 0);
        req_val = 3'b000;
        cyc(-1, 1);
        out_rdy = 1'b0;
        reset = 1'b1;
        #1;
        check("reset async out_val", 32'(out_val), 32'd0);
        exp_q.delete();
        req_msg[7:0] = 8'h87;
        req_val = 3'b011;
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_rdy = 1'b1;
        cyc(0, 0);
        req_val = 3'b000;
        cyc(-1, 1);
        cyc(-1, 1);
        cyc(-1, 0);
        check_drained("post reset drained");

        // Byte 0x7E from requester 2 (nibble order follows the build option).
        req_msg[23:16] = 8'h7E;
        req_val = 3'b100;
        cyc(2, 0);
        req_val = 3'b000;
        cyc(-1, 1);
        cyc(-1, 1);
        cyc(-1, 0);
        check_drained("order drained");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
